// File: rtl/ram_pkg.sv
// Shared definitions for the on-chip RAM family: read-during-write modes,
// sweep FSM states and a generic byte-merge helper.
package ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MERGE_W = 512;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]   old_word,
    input logic [MERGE_W-1:0]   new_word,
    input logic [MERGE_W/8-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_W/8; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_init_sweep.sv
// Clear-sweep engine: walks every address once after reset or on request,
// holding the user ports off via busy while it runs.
module ram_init_sweep
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_req,
  output logic                  busy,
  output logic                  sweep_we,
  output logic [ADDR_WIDTH-1:0] sweep_addr
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;

  // The counter stops being used once the last address is written, so the
  // wrap back to zero on the final increment never triggers a second pass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end
        end
        ST_READY: begin
          if (init_req) begin
            state <= ST_INIT;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign sweep_we   = busy;
  assign sweep_addr = cnt;

endmodule

// File: rtl/ram_dp_be.sv
// Simple-dual-port RAM with byte-enable writes, registered reads, selectable
// read-during-write behaviour and a self-clearing sweep after reset.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 7,
  parameter int                  RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_req,
  output logic                    busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int DEPTH       = 2**ADDR_WIDTH;
  localparam bit WRITE_FIRST = (RDW_MODE == RDW_NEW);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  sweep_we;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_fire;

  ram_init_sweep #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sweep (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_req   (init_req),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  assign wr_merged = DATA_WIDTH'(byte_merge(MERGE_W'(mem[wr_addr]),
                                            MERGE_W'(wr_data),
                                            (MERGE_W/8)'(wr_be)));

  // Sweep owns the write port while busy; user writes are dropped then.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= INIT_VALUE;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  // Write-first forwards the merged word; read-first sees the array as it
  // stood before this edge's write.
  assign rd_word = (WRITE_FIRST && wr_en && (wr_addr == rd_addr)) ? wr_merged
                                                                  : mem[rd_addr];
  assign rd_fire = rd_en && !busy;

  // Read register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// Scoreboard bench for ram_dp_be: three instances (read-first, write-first
// with non-zero init, and a 16x16 variant) share one stimulus stream.
module tb_ram_dp_be;

  typedef struct {
    logic        init;
    logic        we;
    int          wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    int          ra;
  } op_t;

  typedef struct {
    logic [31:0] d;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        init_req, wr_en, rd_en;
  logic [6:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [3:0]  wr_addr_c, rd_addr_c;
  logic [15:0] wr_data_c;
  logic [1:0]  wr_be_c;

  logic        busy_a, busy_b, busy_c;
  logic        rdv_a, rdv_b, rdv_c;
  logic [31:0] rdd_a, rdd_b;
  logic [15:0] rdd_c;

  logic        busy_w [3];
  logic        rdv_w  [3];
  logic [31:0] rdd_w  [3];

  ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .RDW_MODE(0), .INIT_VALUE(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd_a), .rd_valid(rdv_a));

  ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .RDW_MODE(1), .INIT_VALUE(32'h5A5A5A5A)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd_b), .rd_valid(rdv_b));

  ram_dp_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(0), .INIT_VALUE(16'h0)) dut_c (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy_c),
    .wr_en(wr_en), .wr_addr(wr_addr_c), .wr_data(wr_data_c), .wr_be(wr_be_c),
    .rd_en(rd_en), .rd_addr(rd_addr_c), .rd_data(rdd_c), .rd_valid(rdv_c));

  assign busy_w[0] = busy_a;
  assign busy_w[1] = busy_b;
  assign busy_w[2] = busy_c;
  assign rdv_w[0]  = rdv_a;
  assign rdv_w[1]  = rdv_b;
  assign rdv_w[2]  = rdv_c;
  assign rdd_w[0]  = rdd_a;
  assign rdd_w[1]  = rdd_b;
  assign rdd_w[2]  = {16'h0, rdd_c};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: per-instance word array, remaining sweep cycles, last read.
  int          depth [3] = '{128, 128, 16};
  logic [31:0] initv [3] = '{32'h0, 32'h5A5A5A5A, 32'h0};
  bit          rdw   [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] dmask [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF};
  logic [31:0] mem   [3][128];
  int          left  [3];
  logic [31:0] last  [3];
  logic        exp_busy [3] = '{1'b1, 1'b1, 1'b1};
  exp_t        q [3][$];

  int cyc   = 0;
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%08h required 0x%08h", nm, cyc, act, req);
    end
  endtask

  function automatic logic [31:0] mrg(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic op_t mk(logic we, int wa, logic [31:0] wd, logic [3:0] be,
                             logic re, int ra, logic init);
    op_t o;
    o.we = we; o.wa = wa; o.wd = wd; o.be = be;
    o.re = re; o.ra = ra; o.init = init;
    return o;
  endfunction

  function automatic op_t idle();
    return mk(1'b0, 0, 32'h0, 4'h0, 1'b0, 0, 1'b0);
  endfunction

  function automatic op_t rd(int a);
    return mk(1'b0, 0, 32'h0, 4'h0, 1'b1, a, 1'b0);
  endfunction

  function automatic op_t wr(int a, logic [31:0] d, logic [3:0] be);
    return mk(1'b1, a, d, be, 1'b0, 0, 1'b0);
  endfunction

  function automatic op_t rnd();
    op_t o;
    o.ra   = int'($urandom_range(0, 127));
    o.wa   = ($urandom_range(0, 2) == 0) ? o.ra : int'($urandom_range(0, 127));
    o.wd   = $urandom;
    o.be   = 4'($urandom);
    o.we   = 1'($urandom);
    o.re   = 1'($urandom);
    o.init = ($urandom_range(0, 149) == 0);
    return o;
  endfunction

  task automatic model(int k, op_t o, logic rst);
    int          wa, ra;
    logic [31:0] wd, old, r;
    logic [3:0]  be;
    wa = o.wa % depth[k];
    ra = o.ra % depth[k];
    wd = o.wd & dmask[k];
    be = (k == 2) ? (o.be & 4'h3) : o.be;
    if (!rst) begin
      for (int i = 0; i < depth[k]; i++) mem[k][i] = initv[k];
      left[k] = depth[k];
      last[k] = 32'h0;
    end else if (left[k] > 0) begin
      left[k]--;
    end else begin
      old = mem[k][ra];
      if (o.re) begin
        r = (rdw[k] && o.we && (wa == ra)) ? mrg(old, wd, be) : old;
        q[k].push_back('{d: r, cyc: cyc + 1});
        last[k] = r;
      end
      if (o.we) mem[k][wa] = mrg(mem[k][wa], wd, be);
      if (o.init) begin
        for (int i = 0; i < depth[k]; i++) mem[k][i] = initv[k];
        left[k] = depth[k];
      end
    end
    exp_busy[k] = (left[k] > 0);
  endtask

  task automatic step(op_t o, logic rst);
    rst_n     = rst;
    init_req  = o.init;
    wr_en     = o.we;
    wr_addr   = 7'(o.wa);
    wr_data   = o.wd;
    wr_be     = o.be;
    rd_en     = o.re;
    rd_addr   = 7'(o.ra);
    wr_addr_c = 4'(o.wa);
    rd_addr_c = 4'(o.ra);
    wr_data_c = o.wd[15:0];
    wr_be_c   = o.be[1:0];
    for (int k = 0; k < 3; k++) model(k, o, rst);
    @(negedge clk);
  endtask

  task automatic chk_hold();
    for (int k = 0; k < 3; k++) chk($sformatf("rd_data_hold%0d", k), rdd_w[k], last[k]);
  endtask

  // Monitor: busy every cycle, and each rd_valid against the queued read.
  always @(posedge clk) begin
    exp_t e;
    logic want;
    cyc = cyc + 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(exp_busy[k]));
      want = (q[k].size() > 0) && (q[k][0].cyc == cyc);
      chk($sformatf("rd_valid%0d", k), 32'(rdv_w[k]), 32'(want));
      if (want) begin
        e = q[k].pop_front();
        if (rdv_w[k] === 1'b1) chk($sformatf("rd_data%0d", k), rdd_w[k], e.d);
      end
    end
  end

  initial begin
    step(idle(), 1'b0);
    step(idle(), 1'b0);
    chk_hold();
    repeat (128) step(idle(), 1'b1);

    for (int a = 0; a < 128; a++) step(rd(a), 1'b1);

    step(wr(5, 32'hDEADBEEF, 4'hF), 1'b1);
    step(wr(5, 32'h11223344, 4'h5), 1'b1);
    step(rd(5), 1'b1);
    step(mk(1'b1, 9, 32'hA5A5A5A5, 4'hF, 1'b1, 9, 1'b0), 1'b1);
    step(wr(3, 32'h0000ABCD, 4'h2), 1'b1);
    step(rd(3), 1'b1);
    step(wr(40, 32'hCAFEF00D, 4'hF), 1'b1);
    step(rd(40), 1'b1);
    step(wr(40, 32'h12345678, 4'h0), 1'b1);
    step(rd(40), 1'b1);

    repeat (400) step(rnd(), 1'b1);
    repeat (130) step(idle(), 1'b1);

    for (int a = 0; a < 128; a++) step(wr(a, 32'(a), 4'hF), 1'b1);
    step(mk(1'b1, 127, 32'hFFFFFFFF, 4'hF, 1'b1, 127, 1'b1), 1'b1);
    for (int i = 0; i < 128; i++)
      step(mk(1'b1, i, $urandom, 4'hF, 1'b1, i, 1'b0), 1'b1);
    step(rd(127), 1'b1);
    step(rd(0), 1'b1);
    step(idle(), 1'b1);
    chk_hold();

    step(mk(1'b0, 0, 32'h0, 4'h0, 1'b0, 0, 1'b1), 1'b1);
    repeat (60) step(idle(), 1'b1);
    step(idle(), 1'b0);
    chk_hold();
    repeat (128) step(rnd(), 1'b1);
    step(rd(60), 1'b1);
    step(rd(127), 1'b1);

    repeat (300) step(rnd(), 1'b1);
    repeat (3) step(idle(), 1'b1);

    for (int k = 0; k < 3; k++)
      chk($sformatf("pending_reads%0d", k), 32'(q[k].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
